// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequenced ALU controller: FSM states, opcodes, idle drive.
// No logic or latency of its own; nothing here applies backpressure.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_e;

  localparam logic [3:0] OP_PASS  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_DEC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_LAST  = 4'd9;
  localparam logic [3:0] ALU_IDLE = 4'hF;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x 16-bit register file: writeback and host write ports (writeback wins on a clash), three
// combinational read ports; writes land on the next edge and there is no backpressure.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [15:0]     wb_wdata,
  input  logic            host_we,
  input  logic [RA_W-1:0] host_addr,
  input  logic [15:0]     host_wdata,
  input  logic [RA_W-1:0] ra_addr,
  output logic [15:0]     ra_data,
  input  logic [RA_W-1:0] rb_addr,
  output logic [15:0]     rb_data,
  input  logic [RA_W-1:0] rh_addr,
  output logic [15:0]     rh_data
);

  logic [15:0] regs_q [NREG];
  logic [15:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NREG; i++) begin
      if (wb_we && wb_addr == RA_W'(i)) begin
        regs_d[i] = wb_wdata;
      end else if (host_we && host_addr == RA_W'(i)) begin
        regs_d[i] = host_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rh_data = regs_q[rh_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state command sequencer driving an external ALU from a local register file.
// Accept at edge N, done/err pulse and cmd_ready back in cycle N+3; cmd_valid is ignored while busy.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [RA_W-1:0] cmd_rd,
  input  logic [RA_W-1:0] cmd_ra,
  input  logic [RA_W-1:0] cmd_rb,
  input  logic            cmd_usec,
  input  logic            cmd_cin,
  input  logic            host_we,
  input  logic [RA_W-1:0] host_addr,
  input  logic [15:0]     host_wdata,
  input  logic [RA_W-1:0] host_raddr,
  output logic [15:0]     host_rdata,
  output logic [3:0]      alu_s,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic            alu_cin,
  input  logic [15:0]     alu_f,
  input  logic            alu_cout,
  output logic            done,
  output logic            err,
  output logic            carry
);

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [RA_W-1:0] rd_q, ra_q, rb_q;
  logic            usec_q, cin_q;
  logic [15:0]     opa_q, opb_q, res_q;
  logic            cout_q, carry_q, done_q, err_q;
  logic            wb_we;
  logic [15:0]     ra_data, rb_data;

  alu_seq_regfile #(.NREG(NREG), .RA_W(RA_W)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_we      (wb_we),
    .wb_addr    (rd_q),
    .wb_wdata   (res_q),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ra_addr    (ra_q),
    .ra_data    (ra_data),
    .rb_addr    (rb_q),
    .rb_data    (rb_data),
    .rh_addr    (host_raddr),
    .rh_data    (host_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = FETCH;
      FETCH:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    alu_s     = ALU_IDLE;
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    wb_we     = 1'b0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      EXEC: begin
        alu_s   = op_q;
        alu_a   = opa_q;
        alu_b   = opb_q;
        alu_cin = cin_q;
      end
      WB:      wb_we = op_legal(op_q);
      default: ;
    endcase
  end

  // Carry is sampled in FETCH so a preceding command's writeback is already reflected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      usec_q  <= 1'b0;
      cin_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          rd_q   <= cmd_rd;
          ra_q   <= cmd_ra;
          rb_q   <= cmd_rb;
          usec_q <= cmd_usec;
          cin_q  <= cmd_cin;
        end
        FETCH: begin
          opa_q <= ra_data;
          opb_q <= rb_data;
          if (usec_q) cin_q <= carry_q;
        end
        EXEC: begin
          res_q  <= alu_f;
          cout_q <= alu_cout;
        end
        WB: begin
          if (op_legal(op_q)) begin
            carry_q <= cout_q;
            done_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done  = done_q;
  assign err   = err_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural ALU alongside; directed commands push expected
// writebacks to a scoreboard that a monitor pops on every done/err pulse.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_rd, cmd_ra, cmd_rb;
  logic        cmd_usec, cmd_cin;
  logic        host_we;
  logic [1:0]  host_addr, host_raddr;
  logic [15:0] host_wdata, host_rdata;
  logic [3:0]  alu_s;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        alu_cin, alu_cout;
  logic        done, err, carry;

  logic        stim_rd_en = 1'b0;
  logic [1:0]  stim_raddr = '0;
  logic [1:0]  mon_raddr  = '0;
  assign host_raddr = stim_rd_en ? stim_raddr : mon_raddr;

  alu_seq_ctrl #(.NREG(4), .RA_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_usec(cmd_usec), .cmd_cin(cmd_cin),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .done(done), .err(err), .carry(carry)
  );

  // External ALU: arithmetic ops fold cin in; logic ops give cout=0; shifts carry out the lost bit.
  logic [16:0] sum;
  always_comb begin
    sum      = '0;
    alu_f    = '0;
    alu_cout = 1'b0;
    case (alu_s)
      4'd0: sum = {1'b0, alu_a} + 17'(alu_cin);
      4'd1: sum = {1'b0, alu_a} + {1'b0, alu_b} + 17'(alu_cin);
      4'd2: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'(alu_cin);
      4'd3: sum = {1'b0, alu_a} + 17'h0FFFF + 17'(alu_cin);
      4'd4: sum = {1'b0, alu_a & alu_b};
      4'd5: sum = {1'b0, alu_a | alu_b};
      4'd6: sum = {1'b0, alu_a ^ alu_b};
      4'd7: sum = {1'b0, ~alu_a};
      4'd8: sum = {alu_a[0], 1'b0, alu_a[15:1]};
      4'd9: sum = {alu_a[15], alu_a[14:0], 1'b0};
      default: sum = '0;
    endcase
    alu_f    = sum[15:0];
    alu_cout = sum[16];
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    logic [1:0]  rd;
    logic [15:0] val;
    logic        c;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done_err", {30'd0, done, err}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done", 32'(done), 32'(!e.is_err));
          chk("err", 32'(err), 32'(e.is_err));
          chk("latency", cyc, e.due);
          chk("carry", 32'(carry), 32'(e.c));
          mon_raddr = e.rd;
          #1;
          chk("reg_wb", 32'(host_rdata), 32'(e.val));
        end
      end
    end
  end

  task automatic hwrite(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic usec, input logic cin,
                       input logic [15:0] val, input logic c, input logic hold, input logic push,
                       input logic hw, input logic [1:0] ha, input logic [15:0] hd,
                       output int acc);
    int n = 0;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_usec = usec; cmd_cin = cin;
    cmd_valid = 1'b1;
    host_we = hw; host_addr = ha; host_wdata = hd;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    @(posedge clk); #1;
    acc = cyc;
    host_we = 1'b0;
    if (!hold) cmd_valid = 1'b0;
    if (push) sbq.push_back('{op > 4'd9, rd, val, c, cyc + 3});
  endtask

  task automatic cmd(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                     input logic [1:0] rb, input logic usec, input logic cin,
                     input logic [15:0] val, input logic c);
    int acc;
    issue(op, rd, ra, rb, usec, cin, val, c, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_regs_zero(input string name);
    stim_rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stim_raddr = 2'(i);
      #1;
      chk(name, 32'(host_rdata), 32'd0);
    end
    stim_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_usec = 1'b0; cmd_cin = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_s", 32'(alu_s), 32'hF);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    check_regs_zero("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 5 + 3 -> 8; FETCH keeps idle ALU drive, EXEC presents operands.
    hwrite(2'd0, 16'h0005);
    hwrite(2'd1, 16'h0003);
    issue(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, a0);
    chk("fetch_alu_s", 32'(alu_s), 32'hF);
    chk("fetch_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("exec_alu_s", 32'(alu_s), 32'd1);
    chk("exec_alu_a", 32'(alu_a), 32'h5);
    chk("exec_alu_b", 32'(alu_b), 32'h3);
    chk("exec_alu_cin", 32'(alu_cin), 32'd0);
    drain();

    // Overflow sets carry; PASS r1 with usec picks it up: 1 + 1 = 2.
    hwrite(2'd0, 16'hFFFF);
    hwrite(2'd1, 16'h0001);
    cmd(4'd1, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 1'b1);
    cmd(4'd0, 2'd1, 2'd1, 2'd1, 1'b1, 1'b0, 16'h0002, 1'b0);

    // Host write of r0 in the accept cycle is seen by FETCH: 0x10 + 2 + 1.
    issue(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 16'h0013, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0010, a0);
    cmd(4'd2, 2'd3, 2'd0, 2'd1, 1'b0, 1'b1, 16'h000E, 1'b1);
    cmd(4'hC, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0013, 1'b1);
    cmd(4'd4, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0000, 1'b0);
    drain();

    // cmd_valid held high across three commands.
    issue(4'd6, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0, 16'h001D, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0, a0);
    issue(4'd5, 2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 16'h001F, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0, a1);
    issue(4'd8, 2'd2, 2'd1, 2'd0, 1'b0, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, a2);
    chk("b2b_gap1", a1 - a0, 4);
    chk("b2b_gap2", a2 - a1, 4);
    drain();

    // Host write to r2 in the WB cycle loses to the writeback.
    hwrite(2'd0, 16'h0005);
    hwrite(2'd1, 16'h0003);
    issue(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, a0);
    @(posedge clk); @(posedge clk); #1;
    host_we = 1'b1; host_addr = 2'd2; host_wdata = 16'h1234;
    @(posedge clk); #1;
    host_we = 1'b0;
    drain();
    cmd(4'd7, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFA, 1'b0);
    hwrite(2'd3, 16'h000E);
    cmd(4'd3, 2'd3, 2'd3, 2'd0, 1'b0, 1'b0, 16'h000D, 1'b1);
    cmd(4'd9, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 16'h001A, 1'b0);
    drain();

    // Reset in EXEC aborts the command.
    issue(4'd1, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, a0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("exec_rst_alu_s", 32'(alu_s), 32'hF);
    chk("exec_rst_alu_a", 32'(alu_a), 32'd0);
    check_regs_zero("exec_rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst2", 32'(cmd_ready), 32'd1);
    chk("carry_after_rst2", 32'(carry), 32'd0);
    repeat (5) @(negedge clk);

    // usec=1 with carry 0 must ignore cmd_cin=1.
    hwrite(2'd0, 16'h0007);
    hwrite(2'd1, 16'h0009);
    cmd(4'd1, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 16'h0011, 1'b0);
    cmd(4'd1, 2'd3, 2'd0, 2'd1, 1'b1, 1'b1, 16'h0010, 1'b0);
    drain();

    chk("scoreboard_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 4, number of 16-bit registers (power of 2, 2..16).
REQ-002 SHALL have parameter RA_W, default 2, register-index width, equal to log2(NREG).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller accepts a command; high only in IDLE.
REQ-007 cmd_op  input  4  ALU select code.
REQ-008 cmd_rd / cmd_ra / cmd_rb  input  RA_W each  destination and operand register indices.
REQ-009 cmd_usec  input  1  1 = drive cin from the carry flag; 0 = drive cin from cmd_cin.
REQ-010 cmd_cin  input  1  explicit carry-in.
REQ-011 host_we / host_addr / host_wdata  input  1 / RA_W / 16  host register load.
REQ-012 host_raddr / host_rdata  input RA_W / output 16  combinational register readback.
REQ-013 alu_s / alu_a / alu_b / alu_cin  output  4 / 16 / 16 / 1  drive the external ALU.
REQ-014 alu_f / alu_cout  input  16 / 1  ALU result and carry.
REQ-015 done  output  1  one-cycle pulse on writeback.
REQ-016 err  output  1  one-cycle pulse for an illegal opcode.
REQ-017 carry  output  1  registered carry flag.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, EXEC and WB; all other encodings return to IDLE.
REQ-019 IDLE: cmd_valid && cmd_ready SHALL latch op, rd, ra, rb, usec and cin and move to FETCH.
REQ-020 FETCH SHALL register regs[ra] to opA and regs[rb] to opB; for usec=1, cin SHALL be the carry flag value at this edge; next state EXEC.
REQ-021 EXEC SHALL drive alu_s=op, alu_a=opA, alu_b=opB, alu_cin=cin and register alu_f and alu_cout; next state WB.
REQ-022 Outside EXEC, alu_s SHALL be 4'hF and alu_a, alu_b and alu_cin SHALL be 0.
REQ-023 For legal op 0..9, WB SHALL write the result to regs[rd], load carry with the sampled cout, pulse done and return to IDLE.
REQ-024 Latency SHALL be fixed: accept at edge N, done high during cycle N+3, and cmd_ready high again in cycle N+3.
REQ-025 For op 10..15, WB SHALL leave regs and carry unchanged, pulse err and not pulse done.
REQ-026 For ops 4..7, the carry flag SHALL be loaded with 0 because ALU cout is 0.
REQ-027 rd equal to ra or rb SHALL be legal; the operands are the pre-write values.
REQ-028 A host write SHALL apply in any state when host_we=1.
REQ-029 If a host write and a WB write target the same register in the same cycle, the WB write SHALL win; on different registers, both SHALL apply.
REQ-030 A host write in the cycle of command accept SHALL be visible to FETCH.
REQ-031 host_rdata SHALL equal regs[host_raddr] combinationally.
REQ-032 The controller SHALL hold no command queue; cmd_valid outside IDLE SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, all regs, opA, opB, the result register and carry to 0, done and err to 0, and the ALU drive to the REQ-022 idle values.
REQ-034 A reset during FETCH, EXEC or WB SHALL abort the command with no writeback, done or err.
REQ-035 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-036 A shared package SHALL hold the state enum, the ALU opcode constants (PASS=0, ADD=1, SUB=2, DEC=3, AND=4, OR=5, XOR=6, NOT=7, SHR=8, SHL=9), OP_LAST=9 and ALU_IDLE=4'hF.
REQ-037 The register file SHALL be one sub-module, alu_seq_regfile, with two synchronous write ports (WB port priority) and three combinational read ports.
REQ-038 The ALU SHALL stay outside this block; the bench SHALL instantiate it next to the controller.

Verification
REQ-039 Host loads r0=0x0005, r1=0x0003; ADD rd=2, ra=0, rb=1, cin=0 -> done at N+3, r2=0x0008, carry=0.
REQ-040 r0=0xFFFF, r1=0x0001; ADD rd=3, cin=0 -> r3=0x0000, carry=1; then PASS rd=1, rb=1, usec=1 -> r1=0x0002.
REQ-041 Back-to-back cmd_valid held high -> accepts exactly every 4th cycle, with no accepts in FETCH, EXEC or WB.
REQ-042 op=0xC -> err pulse at N+3, no done, regs and carry unchanged.
REQ-043 rst_n low during EXEC -> all regs 0, no done, cmd_ready=1 the cycle after release.
REQ-044 Host write to r2=0x1234 in the WB cycle of a command with rd=2 and result 0x0008 -> r2=0x0008.
